fb_pixel_packer: RTL and testbench
==================================

# fb_pixel_packer

Write-side companion to the 1-bpp VGA framebuffer peripheral. Accepts a raster-ordered stream of 1-bit pixels (valid/ready) and packs 32 pixels per word. Issues word writes on the framebuffer write port, placing each visible row at the word offsets the display scans out. Also provides a hardware clear of the visible area, so software does not have to stream 9600 zero words.

## Interface
- BASE_WORD, 825: word address of row 0, column 0 (33 back-porch lines × 25 words).
- LINE_WORDS, 25: word stride between rows (1600 clk per line / 64 clk per word).
- ACTIVE_WORDS, 20: visible words per row (640 px / 32).
- ROWS, 480: visible rows per frame.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  1  pixel value, 1 = white.
- pix_sof  in  1  qualifies the current pixel as first of a frame.
- pix_ready  out  1  packer accepts a pixel this cycle.
- clear_req  in  1  one-cycle request to zero the visible area.
- busy  out  1  clear in progress.
- frame_done  out  1  one-cycle pulse with the final write of a frame.
- err_sof  out  1  one-cycle pulse on a misaligned SOF (macro only).
- fb_write  out  1  framebuffer write strobe.
- fb_address  out  15  framebuffer word address.
- fb_writedata  out  32  packed pixels, bit 0 = leftmost pixel.

## Operation
- States:
  - PACK (reset state).
  - CLEAR.
- pix_ready = (state == PACK). A pixel is accepted when pix_valid & pix_ready.
- Position registers:
  - bit (5 b, 0..31)
  - wcol (0..ACTIVE_WORDS-1)
  - row (0..ROWS-1)
  - line_base (15 b), which starts at BASE_WORD and increments by LINE_WORDS per row. No multiplier is used.
- Each accepted pixel loads shift[bit] and increments bit.
- When bit 31 is accepted:
  - Register the word with the new bit included.
  - Set address = line_base + wcol and assert fb_write.
  - Reset bit to 0 and increment wcol.
- When wcol wraps, row increments and line_base += LINE_WORDS.
- When row wraps:
  - Pulse frame_done together with the final write.
  - Return line_base to BASE_WORD.
- In PACK, clear_req discards any partial word and any pixel accepted that cycle. The block then enters CLEAR with the position at the origin.
- In CLEAR:
  - One write of 0 per cycle, sweeping every (row, wcol) in raster order: 9600 writes.
  - Return to PACK after the last write.
  - busy is high for exactly those cycles.
  - frame_done does not pulse.
  - clear_req is ignored.
- Address arithmetic is 15-bit unsigned. Defaults peak at 12819, so no wrap occurs.

## Timing
- Reset values:
  - fb_write = 0, fb_address = 0, fb_writedata = 0.
  - busy = 0, frame_done = 0, err_sof = 0.
  - pix_ready = 1.
  - Position at origin, state PACK.
- Write latency: fb_write is asserted 1 cycle after the 32nd pixel of a word is accepted. It is a single-cycle strobe.
- The framebuffer never stalls, so pix_ready stays high throughout PACK.
- At most one write per cycle.
- Reset mid-frame or mid-clear abandons all work immediately. No write is issued after reset asserts.

## Configuration
- FB_PACKER_SOF_CHECK_EN defined:
  - An accepted pixel with pix_sof=1 while the position is not at the origin does the following:
    - Flushes the partial word (unfilled bits 0) to the current address on the next cycle.
    - Pulses err_sof in that cycle.
    - Stores the SOF pixel at bit 0 of the origin word.
  - pix_sof at the origin is silent.
- FB_PACKER_SOF_CHECK_EN undefined:
  - pix_sof is ignored. Frame position is purely count-based.
  - err_sof is tied to 0.

## Structure
- Package fb_pkg holds:
  - FB_ADDR_W=15, FB_DATA_W=32.
  - Default geometry constants shared with the display block.
  - The state enum typedef {PACK, CLEAR}.
- One sub-module, fb_raster_pos, contains the bit/wcol/row/line_base counters, with advance, restart and wrap outputs. PACK and CLEAR both use it.

## Test plan
- 32 pixels alternating 1,0 from reset -> one write, addr 825, data 0x55555555, 1 cycle after the last pixel.
- 640 pixels of 1 -> 20 writes, addr 825..844, data 0xFFFFFFFF. The 641st..672nd pixels write addr 850.
- Full frame of 307200 pixels at pix_valid=1 -> 9600 writes; last write addr 12819 with frame_done. The next frame's first word goes to 825.
- clear_req after 10 pixels -> partial word discarded; busy high and pix_ready low for 9600 cycles; 9600 zero writes covering 825..12819 visible addresses. Then 32 pixels write to 825.
- With macro: 40 ones, then a pixel with pix_sof=1 -> write addr 826 data 0x000000FF, err_sof pulse. 31 more pixels then write to 825.
- Reset asserted mid-clear -> fb_write 0 at once; after release, pix_ready = 1 and the next word goes to 825.

Source files
------------

// File: rtl/fb_pixel_packer_pkg.sv
// Shared constants and types for the 1-bpp framebuffer pixel packer.
// The default geometry matches the VGA display block's scan-out layout.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 32;
  localparam int FB_BIT_W  = 5;

  localparam int DEF_BASE_WORD    = 825;
  localparam int DEF_LINE_WORDS   = 25;
  localparam int DEF_ACTIVE_WORDS = 20;
  localparam int DEF_ROWS         = 480;

  typedef enum logic [0:0] {
    PACK  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_raster_pos.sv
// Raster position tracker: bit within word, word column, row and row base
// address. Steps per pixel (bit mode) or per whole word (word_mode).
module fb_raster_pos
  import fb_pkg::*;
#(
  parameter int BASE_WORD    = DEF_BASE_WORD,
  parameter int LINE_WORDS   = DEF_LINE_WORDS,
  parameter int ACTIVE_WORDS = DEF_ACTIVE_WORDS,
  parameter int ROWS         = DEF_ROWS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  logic                 word_mode,
  input  logic                 restart,
  output logic [FB_BIT_W-1:0]  bit_idx,
  output logic [FB_ADDR_W-1:0] address,
  output logic                 at_origin,
  output logic                 word_end,
  output logic                 frame_end
);

  localparam int WCOL_W = $clog2(ACTIVE_WORDS + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);

  logic [WCOL_W-1:0]    wcol;
  logic [ROW_W-1:0]     row;
  logic [FB_ADDR_W-1:0] line_base;
  logic                 row_end;

  always_comb begin
    word_end  = word_mode || (bit_idx == FB_BIT_W'(31));
    row_end   = word_end && (wcol == WCOL_W'(ACTIVE_WORDS - 1));
    frame_end = row_end && (row == ROW_W'(ROWS - 1));
    at_origin = (bit_idx == '0) && (wcol == '0) && (row == '0);
    address   = line_base + FB_ADDR_W'(wcol);
  end

  // restart together with advance lands one pixel past the origin: the
  // accepted pixel itself becomes bit 0 of the first word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      wcol      <= '0;
      row       <= '0;
      line_base <= FB_ADDR_W'(BASE_WORD);
    end else if (restart) begin
      bit_idx   <= advance ? FB_BIT_W'(1) : '0;
      wcol      <= '0;
      row       <= '0;
      line_base <= FB_ADDR_W'(BASE_WORD);
    end else if (advance) begin
      if (!word_end) begin
        bit_idx <= bit_idx + FB_BIT_W'(1);
      end else begin
        bit_idx <= '0;
        if (row_end) begin
          wcol <= '0;
          if (frame_end) begin
            row       <= '0;
            line_base <= FB_ADDR_W'(BASE_WORD);
          end else begin
            row       <= row + ROW_W'(1);
            line_base <= line_base + FB_ADDR_W'(LINE_WORDS);
          end
        end else begin
          wcol <= wcol + WCOL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fb_pixel_packer.sv
// Packs a 1-bit raster pixel stream into 32-bit framebuffer words and offers a
// hardware clear of the visible area. Define FB_PACKER_SOF_CHECK_EN for SOF realignment.
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int BASE_WORD    = DEF_BASE_WORD,
  parameter int LINE_WORDS   = DEF_LINE_WORDS,
  parameter int ACTIVE_WORDS = DEF_ACTIVE_WORDS,
  parameter int ROWS         = DEF_ROWS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic                 pix_data,
  input  logic                 pix_sof,
  output logic                 pix_ready,
  input  logic                 clear_req,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_sof,
  output logic                 fb_write,
  output logic [FB_ADDR_W-1:0] fb_address,
  output logic [FB_DATA_W-1:0] fb_writedata
);

  fb_state_t            state;
  logic [FB_DATA_W-1:0] shift;
  logic [FB_DATA_W-1:0] shift_next;
  logic                 accept;
  logic                 sof_err;
  logic                 pos_advance;
  logic                 pos_word_mode;
  logic                 pos_restart;
  logic [FB_BIT_W-1:0]  bit_idx;
  logic [FB_ADDR_W-1:0] pos_address;
  logic                 at_origin;
  logic                 word_end;
  logic                 frame_end;

  assign pix_ready = (state == PACK);
  assign busy      = (state == CLEAR);
  assign accept    = pix_valid && pix_ready;

`ifdef FB_PACKER_SOF_CHECK_EN
  assign sof_err = accept && pix_sof && !at_origin;
`else
  logic unused_sof;
  assign unused_sof = pix_sof ^ at_origin;
  assign sof_err    = 1'b0;
`endif

  always_comb begin
    shift_next          = shift;
    shift_next[bit_idx] = pix_data;
    pos_word_mode       = (state == CLEAR);
    pos_restart         = (state == PACK) && (clear_req || sof_err);
    pos_advance         = (state == CLEAR) || (accept && !clear_req);
  end

  fb_raster_pos #(
    .BASE_WORD    (BASE_WORD),
    .LINE_WORDS   (LINE_WORDS),
    .ACTIVE_WORDS (ACTIVE_WORDS),
    .ROWS         (ROWS)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .advance   (pos_advance),
    .word_mode (pos_word_mode),
    .restart   (pos_restart),
    .bit_idx   (bit_idx),
    .address   (pos_address),
    .at_origin (at_origin),
    .word_end  (word_end),
    .frame_end (frame_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PACK;
      shift        <= '0;
      fb_write     <= 1'b0;
      fb_address   <= '0;
      fb_writedata <= '0;
      frame_done   <= 1'b0;
      err_sof      <= 1'b0;
    end else begin
      fb_write   <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      case (state)
        PACK: begin
          if (clear_req) begin
            state <= CLEAR;
            shift <= '0;
          end else if (sof_err) begin
            // Unfilled bits of the flushed word are already 0 in shift.
            fb_write     <= 1'b1;
            fb_address   <= pos_address;
            fb_writedata <= shift;
            err_sof      <= 1'b1;
            shift        <= FB_DATA_W'(pix_data);
          end else if (accept) begin
            if (word_end) begin
              fb_write     <= 1'b1;
              fb_address   <= pos_address;
              fb_writedata <= shift_next;
              frame_done   <= frame_end;
              shift        <= '0;
            end else begin
              shift <= shift_next;
            end
          end
        end
        CLEAR: begin
          fb_write     <= 1'b1;
          fb_address   <= pos_address;
          fb_writedata <= '0;
          if (frame_end) state <= PACK;
        end
        default: state <= PACK;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Self-checking bench for fb_pixel_packer: vector table, corner-case sequences
// and a randomized stream against a word-index reference model.
module tb_fb_pixel_packer;

  localparam int BASE = 825;
  localparam int LINE = 25;
  localparam int ACT  = 20;
  localparam int SMALL_ROWS = 4;

  logic        clk = 1'b0;
  logic        reset, pix_valid, pix_data, pix_sof, clear_req;
  logic        pix_ready, busy, frame_done, err_sof, fb_write;
  logic [14:0] fb_address;
  logic [31:0] fb_writedata;
  logic        s_pix_ready, s_busy, s_frame_done, s_err_sof, s_fb_write;
  logic [14:0] s_fb_address;
  logic [31:0] s_fb_writedata;

  int tests = 0;
  int fails = 0;

  fb_pixel_packer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .clear_req(clear_req),
    .busy(busy), .frame_done(frame_done), .err_sof(err_sof),
    .fb_write(fb_write), .fb_address(fb_address), .fb_writedata(fb_writedata)
  );

  // Short-frame instance so a full frame wrap fits in a short run.
  fb_pixel_packer #(.ROWS(SMALL_ROWS)) dut_small (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(s_pix_ready), .clear_req(clear_req),
    .busy(s_busy), .frame_done(s_frame_done), .err_sof(s_err_sof),
    .fb_write(s_fb_write), .fb_address(s_fb_address), .fb_writedata(s_fb_writedata)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    logic        fd;
  } wr_t;

  wr_t wq[$];
  wr_t swq[$];
  int  busy_cnt, nready_cnt, es_cnt;

  always @(negedge clk) begin
    if (fb_write)   wq.push_back('{fb_address, fb_writedata, frame_done});
    if (s_fb_write) swq.push_back('{s_fb_address, s_fb_writedata, s_frame_done});
    if (busy)       busy_cnt++;
    if (!pix_ready) nready_cnt++;
    if (err_sof)    es_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] waddr(input int w);
    return 15'(BASE + (w / ACT) * LINE + (w % ACT));
  endfunction

  task automatic do_reset();
    reset = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; pix_sof = 1'b0; clear_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    wq.delete(); swq.delete();
    es_cnt = 0;
  endtask

  task automatic send_pix(input logic d, input logic sof);
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  typedef struct {
    int          npix;
    logic [31:0] pattern;
    int          nwr;
    logic [14:0] first_addr;
    logic [14:0] last_addr;
    logic [31:0] last_data;
  } vec_t;

  vec_t vt[6];

  // Reference model state for the randomized stream (one per geometry).
  typedef struct {
    int          p;
    logic [31:0] word;
  } model_t;

  function automatic void model_push(inout model_t m, input logic d, input int rows,
                                     inout wr_t q[$]);
    int w;
    m.word[m.p % 32] = d;
    m.p++;
    if (m.p % 32 == 0) begin
      w = m.p / 32 - 1;
      q.push_back('{waddr(w), m.word, (m.p == rows * ACT * 32)});
      m.word = '0;
      if (m.p == rows * ACT * 32) m.p = 0;
    end
  endfunction

  initial begin
    int          n, bad, nfd;
    logic [31:0] pat;
    wr_t         exp_q[$];
    wr_t         sexp_q[$];
    model_t      m, sm;

    vt[0] = '{32,   32'h5555_5555, 1,  15'd825, 15'd825, 32'h5555_5555};
    vt[1] = '{31,   32'hAAAA_AAAA, 0,  15'd0,   15'd0,   32'h0};
    vt[2] = '{640,  32'hFFFF_FFFF, 20, 15'd825, 15'd844, 32'hFFFF_FFFF};
    vt[3] = '{672,  32'hFFFF_FFFF, 21, 15'd825, 15'd850, 32'hFFFF_FFFF};
    vt[4] = '{64,   32'hDEAD_BEEF, 2,  15'd825, 15'd826, 32'hDEAD_BEEF};
    vt[5] = '{1280, 32'h0F0F_1234, 40, 15'd825, 15'd869, 32'h0F0F_1234};

    // Reset values
    reset = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; pix_sof = 1'b0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fb_write", fb_write, 0);
    check("rst_fb_address", fb_address, 0);
    check("rst_fb_writedata", fb_writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_pix_ready", pix_ready, 1);

    // Latency: write strobe exactly one cycle after the 32nd pixel
    do_reset();
    pat = 32'h5555_5555;
    for (int i = 0; i < 31; i++) send_pix(pat[i], 1'b0);
    check("lat_no_early_write", fb_write, 0);
    send_pix(pat[31], 1'b0);
    check("lat_write", fb_write, 1);
    check("lat_addr", fb_address, 825);
    check("lat_data", fb_writedata, 32'h5555_5555);
    @(posedge clk); #1;
    check("lat_single_strobe", fb_write, 0);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      pat = vt[v].pattern;
      for (int i = 0; i < vt[v].npix; i++) send_pix(pat[i % 32], 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_nwrites", v), wq.size(), vt[v].nwr);
      if (wq.size() > 0 && vt[v].nwr > 0) begin
        check($sformatf("vec%0d_first_addr", v), wq[0].addr, vt[v].first_addr);
        check($sformatf("vec%0d_last_addr", v), wq[wq.size()-1].addr, vt[v].last_addr);
        check($sformatf("vec%0d_last_data", v), wq[wq.size()-1].data, vt[v].last_data);
      end
    end

    // Clear after 10 pixels; a second request mid-clear is ignored
    do_reset();
    for (int i = 0; i < 10; i++) send_pix(1'b1, 1'b0);
    busy_cnt = 0; nready_cnt = 0;
    clear_req = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0; pix_valid = 1'b0;
    check("clr_busy_high", busy, 1);
    check("clr_ready_low", pix_ready, 0);
    repeat (100) @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    check("clr_finished", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("clr_busy_cycles", busy_cnt, 9600);
    check("clr_notready_cycles", nready_cnt, 9600);
    check("clr_nwrites", wq.size(), 9600);
    bad = 0;
    for (int k = 0; k < wq.size(); k++)
      if (wq[k].addr !== waddr(k % 9600) || wq[k].data !== 32'h0 || wq[k].fd !== 1'b0) bad++;
    check("clr_sweep_errors", bad, 0);
    if (wq.size() > 0) check("clr_last_addr", wq[wq.size()-1].addr, 12819);
    wq.delete();
    for (int i = 0; i < 32; i++) send_pix(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("post_clr_nwrites", wq.size(), 1);
    if (wq.size() > 0) check("post_clr_addr", wq[0].addr, 825);

    // Reset mid-clear
    do_reset();
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("midclr_writing", fb_write, 1);
    reset = 1'b1;
    #1;
    check("midclr_write_drop", fb_write, 0);
    check("midclr_busy_drop", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wq.delete();
    check("midclr_ready", pix_ready, 1);
    for (int i = 0; i < 32; i++) send_pix(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("midclr_nwrites", wq.size(), 1);
    if (wq.size() > 0) check("midclr_addr", wq[0].addr, 825);

    // Misaligned SOF
    do_reset();
    for (int i = 0; i < 40; i++) send_pix(1'b1, 1'b0);
`ifdef FB_PACKER_SOF_CHECK_EN
    send_pix(1'b1, 1'b1);
    check("sof_flush_write", fb_write, 1);
    check("sof_flush_addr", fb_address, 826);
    check("sof_flush_data", fb_writedata, 32'h0000_00FF);
    check("sof_err_pulse", err_sof, 1);
    for (int i = 0; i < 31; i++) send_pix(1'b1, 1'b0);
    check("sof_realign_addr", fb_address, 825);
    check("sof_realign_data", fb_writedata, 32'hFFFF_FFFF);
    check("sof_err_count", es_cnt, 1);
`else
    send_pix(1'b1, 1'b1);
    for (int i = 0; i < 31; i++) send_pix(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("sof_ignored_nwrites", wq.size(), 2);
    if (wq.size() > 1) check("sof_ignored_addr", wq[1].addr, 826);
    check("sof_err_count", es_cnt, 0);
`endif

    // Full frame on the short-frame instance, then the next frame's first word
    do_reset();
    for (int i = 0; i < SMALL_ROWS * 640 + 32; i++) send_pix(i[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("frame_nwrites", swq.size(), SMALL_ROWS * ACT + 1);
    nfd = 0;
    foreach (swq[k]) if (swq[k].fd) nfd++;
    check("frame_done_count", nfd, 1);
    if (swq.size() == SMALL_ROWS * ACT + 1) begin
      check("frame_last_addr", swq[SMALL_ROWS*ACT-1].addr, BASE + (SMALL_ROWS-1)*LINE + ACT-1);
      check("frame_last_fd", swq[SMALL_ROWS*ACT-1].fd, 1);
      check("frame_next_addr", swq[SMALL_ROWS*ACT].addr, 825);
    end

    // Randomized stream with idle gaps against the word-index model
    do_reset();
    m = '{0, '0}; sm = '{0, '0};
    exp_q.delete(); sexp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      pix_valid = ($urandom_range(3) != 0);
      pix_data  = 1'($urandom);
      if (pix_valid) begin
        model_push(m, pix_data, 480, exp_q);
        model_push(sm, pix_data, SMALL_ROWS, sexp_q);
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rand_nwrites", wq.size(), exp_q.size());
    check("rand_small_nwrites", swq.size(), sexp_q.size());
    for (int k = 0; k < wq.size() && k < exp_q.size(); k++)
      check($sformatf("rand_wr%0d", k), {wq[k].fd, wq[k].addr, wq[k].data},
            {exp_q[k].fd, exp_q[k].addr, exp_q[k].data});
    for (int k = 0; k < swq.size() && k < sexp_q.size(); k++)
      check($sformatf("rand_small_wr%0d", k), {swq[k].fd, swq[k].addr, swq[k].data},
            {sexp_q[k].fd, sexp_q[k].addr, sexp_q[k].data});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
